// File: rtl/sdm_pkg.sv
// Shared definitions for the sigma-delta modulator sequencer: FSM state
// encodings and default parameter values.
package sdm_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_FLUSH   = 2'd1,
      ST_RUN     = 2'd2,
      ST_RECOVER = 2'd3
   } sdm_state_t;

   localparam int DEF_BIT_WIDTH    = 4;
   localparam int DEF_INTERP_RATE  = 8;
   localparam int DEF_FLUSH_CYCLES = 24;
   localparam int DEF_OVL_LIMIT    = 16;

   localparam logic [7:0] UNDERRUN_MAX = 8'hFF;

endpackage

// File: rtl/sdm_frame_timer.sv
// Frame phase counter: runs 0..INTERP_RATE-1 and wraps, with a strobe on
// the last phase of every frame.
module sdm_frame_timer
   import sdm_pkg::*;
#(
   parameter int INTERP_RATE = DEF_INTERP_RATE
) (
   input  logic                           clck,
   input  logic                           rst,
   input  logic                           i_clear,
   output logic [$clog2(INTERP_RATE)-1:0] o_phase,
   output logic                           o_wrap
);

   localparam int            PW   = $clog2(INTERP_RATE);
   localparam logic [PW-1:0] LAST = PW'(INTERP_RATE - 1);

   logic [PW-1:0] r_phase;

   always_ff @(posedge clck) begin
      if (rst || i_clear) begin
         r_phase <= '0;
      end else if (r_phase == LAST) begin
         r_phase <= '0;
      end else begin
         r_phase <= r_phase + 1'b1;
      end
   end

   assign o_phase = r_phase;
   assign o_wrap  = (r_phase == LAST);

endmodule

// File: rtl/sdm_sequencer.sv
// Sequencer for a CIC-interpolated sigma-delta modulator: flushes the
// pipeline, feeds one sample per frame, and recovers from loop overload.
module sdm_sequencer
   import sdm_pkg::*;
#(
   parameter int BIT_WIDTH    = DEF_BIT_WIDTH,
   parameter int INTERP_RATE  = DEF_INTERP_RATE,
   parameter int FLUSH_CYCLES = DEF_FLUSH_CYCLES,
   parameter int OVL_LIMIT    = DEF_OVL_LIMIT
) (
   input  logic                 clck,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 stop,
   input  logic [BIT_WIDTH-1:0] in_data,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic                 q_sat,
   output logic                 cic_en,
   output logic                 cic_load,
   output logic [BIT_WIDTH-1:0] cic_data,
   output logic                 loop_en,
   output logic                 loop_clr,
   output logic [1:0]           state,
   output logic                 ovl_flag,
   output logic [7:0]           underrun_cnt
);

   localparam int PW      = $clog2(INTERP_RATE);
   localparam int CNT_MAX = (FLUSH_CYCLES > INTERP_RATE) ? FLUSH_CYCLES : INTERP_RATE;
   localparam int CW      = $clog2(CNT_MAX + 1);
   localparam int SW      = $clog2(OVL_LIMIT + 1);

   localparam logic [PW-1:0] PHASE_PRELAST = PW'(INTERP_RATE - 2);
   localparam logic [CW-1:0] FLUSH_LAST    = CW'(FLUSH_CYCLES - 1);
   localparam logic [CW-1:0] RECOVER_LAST  = CW'(INTERP_RATE - 1);
   localparam logic [SW-1:0] SAT_LAST      = SW'(OVL_LIMIT - 1);

   sdm_state_t           r_state;
   sdm_state_t           w_nextState;
   logic [CW-1:0]        r_stateCnt;
   logic [SW-1:0]        r_satCnt;
   logic [BIT_WIDTH-1:0] r_sample;
   logic                 r_inReady;
   logic                 r_cicEn;
   logic                 r_cicLoad;
   logic [BIT_WIDTH-1:0] r_cicData;
   logic                 r_loopEn;
   logic                 r_loopClr;
   logic                 r_ovlFlag;
   logic [7:0]           r_underrunCnt;

   logic [PW-1:0]        w_phase;
   logic                 w_wrap;
   logic                 w_clear;
   logic                 w_enterFlush;
   logic                 w_active;
   logic                 w_nextStreaming;
   logic                 w_frameEnd;
   logic                 w_trip;
   logic [BIT_WIDTH-1:0] w_sampleNext;

   // Phase restarts at 0 whenever the sequencer is idle or leaving idle.
   assign w_clear = (r_state == ST_IDLE) || (w_nextState == ST_IDLE);

   sdm_frame_timer #(
      .INTERP_RATE (INTERP_RATE)
   ) u_frame_timer (
      .clck    (clck),
      .rst     (rst),
      .i_clear (w_clear),
      .o_phase (w_phase),
      .o_wrap  (w_wrap)
   );

   assign w_trip = (r_state == ST_RUN) && q_sat && (r_satCnt == SAT_LAST);

   always_comb begin
      w_nextState = r_state;
      case (r_state)
         ST_IDLE:    if (start && !stop) w_nextState = ST_FLUSH;
         ST_FLUSH:   if (stop) w_nextState = ST_IDLE;
                     else if (r_stateCnt == FLUSH_LAST) w_nextState = ST_RUN;
         ST_RUN:     if (stop) w_nextState = ST_IDLE;
                     else if (w_trip) w_nextState = ST_RECOVER;
         ST_RECOVER: if (stop) w_nextState = ST_IDLE;
                     else if (r_stateCnt == RECOVER_LAST) w_nextState = ST_RUN;
         default:    w_nextState = ST_IDLE;
      endcase
   end

   assign w_enterFlush    = (r_state == ST_IDLE) && (w_nextState == ST_FLUSH);
   assign w_active        = (r_state != ST_IDLE) && (w_nextState != ST_IDLE);
   assign w_nextStreaming = (w_nextState == ST_RUN) || (w_nextState == ST_RECOVER);
   // in_ready is only ever high on the last phase of a streaming frame, so it
   // doubles as the frame-boundary marker; an aborted frame is not counted.
   assign w_frameEnd      = r_inReady && w_nextStreaming;

   always_comb begin
      w_sampleNext = r_sample;
      if (w_enterFlush) begin
         w_sampleNext = '0;
      end else if (w_frameEnd && in_valid) begin
         w_sampleNext = in_data;
      end
   end

   // State, counters and every output are registered from next-cycle values.
   always_ff @(posedge clck) begin
      if (rst) begin
         r_state       <= ST_IDLE;
         r_stateCnt    <= '0;
         r_satCnt      <= '0;
         r_sample      <= '0;
         r_inReady     <= 1'b0;
         r_cicEn       <= 1'b0;
         r_cicLoad     <= 1'b0;
         r_cicData     <= '0;
         r_loopEn      <= 1'b0;
         r_loopClr     <= 1'b1;
         r_ovlFlag     <= 1'b0;
         r_underrunCnt <= '0;
      end else begin
         r_state <= w_nextState;

         if ((w_nextState != r_state) || (w_nextState == ST_IDLE) || (w_nextState == ST_RUN)) begin
            r_stateCnt <= '0;
         end else begin
            r_stateCnt <= r_stateCnt + 1'b1;
         end

         if ((r_state == ST_RUN) && (w_nextState == ST_RUN) && q_sat) begin
            r_satCnt <= r_satCnt + 1'b1;
         end else begin
            r_satCnt <= '0;
         end

         r_sample  <= w_sampleNext;
         r_inReady <= w_nextStreaming && w_active && (w_phase == PHASE_PRELAST);
         r_cicEn   <= (w_nextState != ST_IDLE);
         r_cicLoad <= w_enterFlush || (w_active && w_wrap);
         r_cicData <= (w_nextState == ST_RUN) ? w_sampleNext : '0;
         r_loopEn  <= (w_nextState == ST_RUN);
         r_loopClr <= (w_nextState != ST_RUN);

         if (w_enterFlush) begin
            r_ovlFlag <= 1'b0;
         end else if ((r_state == ST_RUN) && (w_nextState == ST_RECOVER)) begin
            r_ovlFlag <= 1'b1;
         end

         if (w_enterFlush) begin
            r_underrunCnt <= '0;
         end else if (w_frameEnd && !in_valid && (r_underrunCnt != UNDERRUN_MAX)) begin
            r_underrunCnt <= r_underrunCnt + 8'd1;
         end
      end
   end

   assign state        = r_state;
   assign in_ready     = r_inReady;
   assign cic_en       = r_cicEn;
   assign cic_load     = r_cicLoad;
   assign cic_data     = r_cicData;
   assign loop_en      = r_loopEn;
   assign loop_clr     = r_loopClr;
   assign ovl_flag     = r_ovlFlag;
   assign underrun_cnt = r_underrunCnt;

endmodule

// File: tb/tb_sdm_sequencer.sv
// Self-checking bench for sdm_sequencer: directed scenarios with literal
// expectations, then randomized traffic compared against a behavioural model.
module tb_sdm_sequencer;

   localparam int BW    = 4;
   localparam int RATE  = 8;
   localparam int FLUSH = 24;
   localparam int OVL   = 16;

   logic          clck;
   logic          rst;
   logic          start;
   logic          stop;
   logic [BW-1:0] in_data;
   logic          in_valid;
   logic          in_ready;
   logic          q_sat;
   logic          cic_en;
   logic          cic_load;
   logic [BW-1:0] cic_data;
   logic          loop_en;
   logic          loop_clr;
   logic [1:0]    state;
   logic          ovl_flag;
   logic [7:0]    underrun_cnt;

   int nChecks = 0;
   int nPass   = 0;
   bit cmpEn   = 1'b0;

   // Behavioural model: mode number, frame phase, time in mode, run of q_sat.
   int          mMode       = 0;
   int          mPhase      = 0;
   int          mModeCycles = 0;
   int          mSatRun     = 0;
   logic [BW-1:0] mSample   = '0;
   int          mUnderrun   = 0;
   bit          mOvl        = 1'b0;

   sdm_sequencer #(
      .BIT_WIDTH    (BW),
      .INTERP_RATE  (RATE),
      .FLUSH_CYCLES (FLUSH),
      .OVL_LIMIT    (OVL)
   ) dut (
      .clck         (clck),
      .rst          (rst),
      .start        (start),
      .stop         (stop),
      .in_data      (in_data),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .q_sat        (q_sat),
      .cic_en       (cic_en),
      .cic_load     (cic_load),
      .cic_data     (cic_data),
      .loop_en      (loop_en),
      .loop_clr     (loop_clr),
      .state        (state),
      .ovl_flag     (ovl_flag),
      .underrun_cnt (underrun_cnt)
   );

   initial begin
      clck = 1'b0;
      forever #5 clck = ~clck;
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      nChecks++;
      if (act === exp) begin
         nPass++;
      end else begin
         $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Advance the model by one clock edge using the inputs held this cycle.
   task automatic modelStep();
      bit frameEnd;
      int nextMode;
      if (rst) begin
         mMode = 0; mPhase = 0; mModeCycles = 0; mSatRun = 0;
         mSample = '0; mUnderrun = 0; mOvl = 1'b0;
         return;
      end
      if (mMode == 0) begin
         if (start && !stop) begin
            mMode = 1; mPhase = 0; mModeCycles = 0; mSatRun = 0;
            mSample = '0; mUnderrun = 0; mOvl = 1'b0;
         end
         return;
      end
      if (stop) begin
         mMode = 0; mPhase = 0; mModeCycles = 0; mSatRun = 0;
         return;
      end
      frameEnd = (mMode >= 2) && (mPhase == RATE - 1);
      if (frameEnd) begin
         if (in_valid) mSample = in_data;
         else if (mUnderrun < 255) mUnderrun++;
      end
      nextMode = mMode;
      if (mMode == 1 && mModeCycles + 1 == FLUSH) nextMode = 2;
      if (mMode == 3 && mModeCycles + 1 == RATE) nextMode = 2;
      if (mMode == 2) begin
         mSatRun = q_sat ? mSatRun + 1 : 0;
         if (mSatRun == OVL) begin
            nextMode = 3;
            mOvl = 1'b1;
         end
      end
      if (nextMode != 2) mSatRun = 0;
      mModeCycles = (nextMode != mMode) ? 0 : mModeCycles + 1;
      mMode  = nextMode;
      mPhase = (mPhase + 1) % RATE;
   endtask

   task automatic applyStimulus(input logic r, input logic s, input logic p,
                                input logic v, input logic [BW-1:0] d, input logic q);
      rst = r; start = s; stop = p; in_valid = v; in_data = d; q_sat = q;
      @(posedge clck);
      modelStep();
      #2;
   endtask

   task automatic idleCycles(input int n);
      for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
   endtask

   // Every output is compared against the model on each falling edge.
   always @(negedge clck) begin
      if (cmpEn) begin
         checkOutput("state",     32'(state),        32'(mMode));
         checkOutput("cic_en",    32'(cic_en),       32'(mMode != 0));
         checkOutput("loop_en",   32'(loop_en),      32'(mMode == 2));
         checkOutput("loop_clr",  32'(loop_clr),     32'(mMode != 2));
         checkOutput("in_ready",  32'(in_ready),     32'((mMode >= 2) && (mPhase == RATE - 1)));
         checkOutput("cic_load",  32'(cic_load),     32'((mMode != 0) && (mPhase == 0)));
         checkOutput("cic_data",  32'(cic_data),     32'((mMode == 2) ? mSample : '0));
         checkOutput("ovl_flag",  32'(ovl_flag),     32'(mOvl));
         checkOutput("underrun",  32'(underrun_cnt), 32'(mUnderrun));
      end
   end

   initial begin
      logic r, s, p, v, qv;
      logic [BW-1:0] d;
      int burst;
      rst = 1'b0; start = 1'b0; stop = 1'b0; in_valid = 1'b0; in_data = '0; q_sat = 1'b0;
      burst = 0; qv = 1'b0;

      // Reset values
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0);
      cmpEn = 1'b1;
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0);
      checkOutput("rst_state",    32'(state),        32'd0);
      checkOutput("rst_loop_clr", 32'(loop_clr),     32'd1);
      checkOutput("rst_cic_data", 32'(cic_data),     32'd0);
      checkOutput("rst_underrun", 32'(underrun_cnt), 32'd0);
      checkOutput("rst_in_ready", 32'(in_ready),     32'd0);

      // Start, 24 cycles of flush, then run
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b0);
      checkOutput("flush_entry_state", 32'(state),    32'd1);
      checkOutput("flush_entry_load",  32'(cic_load), 32'd1);
      idleCycles(23);
      checkOutput("flush_last_state", 32'(state),    32'd1);
      checkOutput("flush_last_data",  32'(cic_data), 32'd0);
      idleCycles(1);
      checkOutput("run_entry_state",   32'(state),   32'd2);
      checkOutput("run_entry_loop_en", 32'(loop_en), 32'd1);
      idleCycles(7);
      checkOutput("run_phase7_ready", 32'(in_ready), 32'd1);

      // Handshake of 5 appears next cycle with a single load strobe
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 4'h5, 1'b0);
      checkOutput("sample_data", 32'(cic_data), 32'd5);
      checkOutput("sample_load", 32'(cic_load), 32'd1);
      idleCycles(1);
      checkOutput("sample_load_end", 32'(cic_load), 32'd0);
      checkOutput("sample_hold",     32'(cic_data), 32'd5);

      // Three starved frames
      idleCycles(24);
      checkOutput("underrun_three", 32'(underrun_cnt), 32'd3);
      checkOutput("underrun_hold",  32'(cic_data),     32'd5);

      // 15 saturated cycles do not trip recovery
      for (int i = 0; i < 15; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b1);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
      checkOutput("sat15_state", 32'(state),    32'd2);
      checkOutput("sat15_ovl",   32'(ovl_flag), 32'd0);

      // 16 saturated cycles trip recovery for one frame
      for (int i = 0; i < 15; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b1);
      checkOutput("sat_pre_trip_state", 32'(state), 32'd2);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b1);
      checkOutput("recover_state",    32'(state),    32'd3);
      checkOutput("recover_ovl",      32'(ovl_flag), 32'd1);
      checkOutput("recover_loop_clr", 32'(loop_clr), 32'd1);
      checkOutput("recover_data",     32'(cic_data), 32'd0);
      idleCycles(7);
      checkOutput("recover_last_state", 32'(state), 32'd3);
      idleCycles(1);
      checkOutput("recover_exit_state", 32'(state),    32'd2);
      checkOutput("recover_exit_ovl",   32'(ovl_flag), 32'd1);

      // Stop with start during recovery returns to idle
      for (int i = 0; i < 16; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b1);
      checkOutput("recover2_state", 32'(state), 32'd3);
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, '0, 1'b0);
      checkOutput("stop_state",    32'(state),    32'd0);
      checkOutput("stop_cic_en",   32'(cic_en),   32'd0);
      checkOutput("stop_loop_en",  32'(loop_en),  32'd0);
      checkOutput("stop_in_ready", 32'(in_ready), 32'd0);

      // Restart clears sticky status; then reset at phase 3 of run
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b0);
      checkOutput("restart_ovl",      32'(ovl_flag),     32'd0);
      checkOutput("restart_underrun", 32'(underrun_cnt), 32'd0);
      idleCycles(24);
      checkOutput("rerun_state", 32'(state), 32'd2);
      idleCycles(8);
      checkOutput("rerun_underrun", 32'(underrun_cnt), 32'd1);
      idleCycles(3);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0);
      checkOutput("midrst_state",    32'(state),        32'd0);
      checkOutput("midrst_underrun", 32'(underrun_cnt), 32'd0);
      checkOutput("midrst_loop_clr", 32'(loop_clr),     32'd1);
      checkOutput("midrst_cic_en",   32'(cic_en),       32'd0);
      checkOutput("midrst_load",     32'(cic_load),     32'd0);

      // Randomized traffic with bursty saturation
      for (int i = 0; i < 4000; i++) begin
         if (burst == 0) begin
            burst = $urandom_range(1, 20);
            qv    = 1'($urandom_range(0, 1));
         end
         burst--;
         r = ($urandom_range(0, 599) == 0);
         s = ($urandom_range(0, 29) == 0);
         p = ($urandom_range(0, 199) == 0);
         v = ($urandom_range(0, 3) != 0);
         d = BW'($urandom_range(0, 15));
         applyStimulus(r, s, p, v, d, qv);
      end

      cmpEn = 1'b0;
      $display("%0d/%0d checks passed", nPass, nChecks);
      $finish;
   end

endmodule
